// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch resolve, store formatting and misalignment trap
// A taken branch squashes the next instruction through the registered BranchTaken flag.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [DATA_W-1:0] RtData,
    input  logic [REG_AW-1:0] WriteRegIn,
    input  logic              RegWriteIn,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic              MemToRegIn,
    input  logic              BranchIn,
    input  logic [1:0]        MemSizeIn,
    input  logic [DATA_W-1:0] BranchTargetIn,
    output logic              OutValid,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] StoreData,
    output logic [3:0]        ByteEn,
    output logic [REG_AW-1:0] WriteRegOut,
    output logic              RegWriteOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic              MemToRegOut,
    output logic [1:0]        MemSizeOut,
    output logic [1:0]        AddrLow,
    output logic              BranchTaken,
    output logic [DATA_W-1:0] BranchTarget,
    output logic              Misaligned
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [3:0]        be_q, be_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic              rw_q, rw_d;
    logic              mr_q, mr_d;
    logic              mw_q, mw_d;
    logic              m2r_q, m2r_d;
    logic [1:0]        size_q, size_d;
    logic              bt_q, bt_d;
    logic [DATA_W-1:0] btgt_q, btgt_d;
    logic              mis_q, mis_d;

    logic              load_valid;
    logic              mem_op;
    logic              mis_raw;
    logic [1:0]        a;
    logic [3:0]        be_raw;
    logic [DATA_W-1:0] sd_raw;

    always_comb begin
        a       = ALUResult[1:0];
        mem_op  = MemReadIn | MemWriteIn;
        be_raw  = 4'b1111;
        sd_raw  = RtData;
        mis_raw = 1'b0;
        case (MemSizeIn)
            2'b10: begin
                be_raw  = 4'b0001 << a;
                sd_raw  = {4{RtData[7:0]}};
            end
            2'b01: begin
                be_raw  = a[1] ? 4'b1100 : 4'b0011;
                sd_raw  = {2{RtData[15:0]}};
                mis_raw = a[0];
            end
            default: begin
                // reserved size 11 behaves as a word access
                be_raw  = 4'b1111;
                sd_raw  = RtData;
                mis_raw = (a != 2'b00);
            end
        endcase
    end

    always_comb begin
        // the slot after a taken branch is the delay-free wrong path
        load_valid = InValid & ~Flush & ~bt_q;

        valid_d = 1'b0;
        alu_d   = '0;
        sdata_d = '0;
        be_d    = 4'b0000;
        wreg_d  = '0;
        rw_d    = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        m2r_d   = 1'b0;
        size_d  = 2'b00;
        bt_d    = 1'b0;
        btgt_d  = '0;
        mis_d   = 1'b0;

        if (load_valid) begin
            valid_d = 1'b1;
            alu_d   = ALUResult;
            sdata_d = sd_raw;
            wreg_d  = WriteRegIn;
            m2r_d   = MemToRegIn;
            size_d  = MemSizeIn;
            bt_d    = BranchIn & Zero;
            btgt_d  = BranchTargetIn;
            mis_d   = mem_op & mis_raw;
            be_d    = (mem_op & ~mis_raw) ? be_raw : 4'b0000;
            rw_d    = RegWriteIn & ~mis_d;
            mr_d    = MemReadIn & ~mis_d;
            mw_d    = MemWriteIn & ~mis_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            sdata_q <= '0;
            be_q    <= 4'b0000;
            wreg_q  <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            size_q  <= 2'b00;
            bt_q    <= 1'b0;
            btgt_q  <= '0;
            mis_q   <= 1'b0;
        end else if (!Stall) begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            sdata_q <= sdata_d;
            be_q    <= be_d;
            wreg_q  <= wreg_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            m2r_q   <= m2r_d;
            size_q  <= size_d;
            bt_q    <= bt_d;
            btgt_q  <= btgt_d;
            mis_q   <= mis_d;
        end
    end

    assign OutValid     = valid_q;
    assign ALUResultOut = alu_q;
    assign StoreData    = sdata_q;
    assign ByteEn       = be_q;
    assign WriteRegOut  = wreg_q;
    assign RegWriteOut  = rw_q;
    assign MemReadOut   = mr_q;
    assign MemWriteOut  = mw_q;
    assign MemToRegOut  = m2r_q;
    assign MemSizeOut   = size_q;
    assign AddrLow      = alu_q[1:0];
    assign BranchTaken  = bt_q;
    assign BranchTarget = btgt_q;
    assign Misaligned   = mis_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] rt;
        logic [4:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        br;
        logic [1:0]  size;
        logic [31:0] tgt;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [3:0]  be;
        logic [4:0]  wreg;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [1:0]  size;
        logic [1:0]  alow;
        logic        bt;
        logic [31:0] btgt;
        logic        mis;
    } out_t;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, InValid, Zero;
    logic [31:0] ALUResult, RtData, BranchTargetIn;
    logic [4:0]  WriteRegIn;
    logic        RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, BranchIn;
    logic [1:0]  MemSizeIn;
    logic        OutValid, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, BranchTaken, Misaligned;
    logic [31:0] ALUResultOut, StoreData, BranchTarget;
    logic [3:0]  ByteEn;
    logic [4:0]  WriteRegOut;
    logic [1:0]  MemSizeOut, AddrLow;

    int n_cmp = 0;
    int n_bad = 0;
    out_t  exp_q[$];
    string name_q[$];
    out_t  act;

    always #5 Clk = ~Clk;

    ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .ALUResult(ALUResult), .Zero(Zero), .RtData(RtData), .WriteRegIn(WriteRegIn),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .MemToRegIn(MemToRegIn), .BranchIn(BranchIn), .MemSizeIn(MemSizeIn),
        .BranchTargetIn(BranchTargetIn), .OutValid(OutValid), .ALUResultOut(ALUResultOut),
        .StoreData(StoreData), .ByteEn(ByteEn), .WriteRegOut(WriteRegOut),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .MemToRegOut(MemToRegOut), .MemSizeOut(MemSizeOut), .AddrLow(AddrLow),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Misaligned(Misaligned)
    );

    assign act = {OutValid, ALUResultOut, StoreData, ByteEn, WriteRegOut, RegWriteOut,
                  MemReadOut, MemWriteOut, MemToRegOut, MemSizeOut, AddrLow,
                  BranchTaken, BranchTarget, Misaligned};

    function automatic in_t mk_in(input logic stall, flush, valid, input logic [31:0] alu,
                                  input logic zero, input logic [31:0] rt, input logic [4:0] wreg,
                                  input logic rw, mr, mw, m2r, br, input logic [1:0] size,
                                  input logic [31:0] tgt);
        in_t r;
        r = {stall, flush, valid, alu, zero, rt, wreg, rw, mr, mw, m2r, br, size, tgt};
        return r;
    endfunction

    function automatic out_t mk_out(input logic valid, input logic [31:0] alu, sd,
                                    input logic [3:0] be, input logic [4:0] wreg,
                                    input logic rw, mr, mw, m2r, input logic [1:0] size,
                                    input logic bt, input logic [31:0] btgt, input logic mis);
        out_t r;
        r = {valid, alu, sd, be, wreg, rw, mr, mw, m2r, size, alu[1:0], bt, btgt, mis};
        return r;
    endfunction

    task automatic apply(input in_t i);
        Stall = i.stall; Flush = i.flush; InValid = i.valid; ALUResult = i.alu;
        Zero = i.zero; RtData = i.rt; WriteRegIn = i.wreg; RegWriteIn = i.rw;
        MemReadIn = i.mr; MemWriteIn = i.mw; MemToRegIn = i.m2r; BranchIn = i.br;
        MemSizeIn = i.size; BranchTargetIn = i.tgt;
    endtask

    task automatic issue(input in_t i, input out_t e, input string nm);
        @(negedge Clk);
        apply(i);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_now(input out_t e, input string nm);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, e);
        end
    endtask

    initial begin : monitor
        out_t  e;
        string nm;
        forever begin
            @(posedge Clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s got=%h want=%h", nm, act, e);
                end
            end
        end
    end

    initial begin : stim
        in_t  addi, idle;
        out_t zero_o, e_addi, e_br;
        zero_o = '0;
        idle   = '0;
        addi   = mk_in(0,0,1,32'h55,0,0,5'd8,1,0,0,0,0,2'b00,0);
        e_addi = mk_out(1,32'h55,0,4'b0000,5'd8,1,0,0,0,2'b00,0,0,0);

        Reset = 1'b0;
        apply(idle);
        #2;
        check_now(zero_o, "reset_state");
        @(negedge Clk);
        Reset = 1'b1;

        issue(mk_in(0,0,1,32'h7,0,32'h12345678,5'd3,1,0,0,0,0,2'b00,0),
              mk_out(1,32'h7,32'h12345678,4'b0000,5'd3,1,0,0,0,2'b00,0,0,0), "add");
        issue(mk_in(0,0,1,32'h1003,0,32'hAABBCCDD,0,0,0,1,0,0,2'b10,0),
              mk_out(1,32'h1003,32'hDDDDDDDD,4'b1000,0,0,0,1,0,2'b10,0,0,0), "sb_a3");
        issue(mk_in(0,0,1,32'h1002,0,32'h11223344,0,0,0,1,0,0,2'b00,0),
              mk_out(1,32'h1002,32'h11223344,4'b0000,0,0,0,0,0,2'b00,0,0,1), "sw_misaligned");
        issue(mk_in(0,0,1,32'h1002,0,32'h0000BEEF,5'd5,1,1,0,1,0,2'b01,0),
              mk_out(1,32'h1002,32'hBEEFBEEF,4'b1100,5'd5,1,1,0,1,2'b01,0,0,0), "lh_a2");

        issue(mk_in(0,0,1,0,1,0,0,0,0,0,0,1,2'b00,32'h400),
              mk_out(1,0,0,4'b0000,0,0,0,0,0,2'b00,1,32'h400,0), "beq_taken");
        issue(addi, zero_o, "addi_squashed");
        issue(mk_in(0,0,1,0,0,0,0,0,0,0,0,1,2'b00,32'h800),
              mk_out(1,0,0,4'b0000,0,0,0,0,0,2'b00,0,32'h800,0), "beq_not_taken");
        issue(addi, e_addi, "addi_not_squashed");

        e_br = mk_out(1,0,0,4'b0000,0,0,0,0,0,2'b00,1,32'h500,0);
        issue(mk_in(0,0,1,0,1,0,0,0,0,0,0,1,2'b00,32'h500), e_br, "beq_taken2");
        for (int k = 0; k < 3; k++) begin
            in_t s;
            s = addi;
            s.stall = 1'b1;
            issue(s, e_br, $sformatf("stall_hold_%0d", k));
        end
        issue(addi, zero_o, "squash_after_stall");

        issue(mk_in(0,0,1,32'h9,0,0,5'd2,1,0,0,0,0,2'b00,0),
              mk_out(1,32'h9,0,4'b0000,5'd2,1,0,0,0,2'b00,0,0,0), "add_9");
        issue(mk_in(1,1,1,32'h20,0,0,5'd4,1,0,0,0,0,2'b00,0),
              mk_out(1,32'h9,0,4'b0000,5'd2,1,0,0,0,2'b00,0,0,0), "stall_over_flush");
        issue(mk_in(0,1,1,32'h20,0,0,5'd4,1,0,0,0,0,2'b00,0), zero_o, "flush_bubble");
        issue(mk_in(0,0,0,32'h30,0,0,5'd4,1,0,1,0,0,2'b00,0), zero_o, "invalid_bubble");

        issue(mk_in(0,0,1,32'h2001,0,32'h000000A5,0,0,0,1,0,0,2'b10,0),
              mk_out(1,32'h2001,32'hA5A5A5A5,4'b0010,0,0,0,1,0,2'b10,0,0,0), "sb_a1");
        issue(mk_in(0,0,1,32'h2001,0,32'h00001234,0,0,0,1,0,0,2'b01,0),
              mk_out(1,32'h2001,32'h12341234,4'b0000,0,0,0,0,0,2'b01,0,0,1), "sh_misaligned");
        issue(mk_in(0,0,1,32'h2000,0,32'hCAFEF00D,5'd7,1,1,0,1,0,2'b11,0),
              mk_out(1,32'h2000,32'hCAFEF00D,4'b1111,5'd7,1,1,0,1,2'b11,0,0,0), "lw_size11");
        issue(mk_in(0,0,1,32'h44,1,0,0,0,0,0,0,1,2'b00,32'h600),
              mk_out(1,32'h44,0,4'b0000,0,0,0,0,0,2'b00,1,32'h600,0), "beq_before_reset");

        @(negedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check_now(zero_o, "async_reset");
        apply(idle);
        @(negedge Clk);
        Reset = 1'b1;
        apply(addi);
        exp_q.push_back(e_addi);
        name_q.push_back("first_after_reset");

        repeat (3) @(posedge Clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register directly downstream of the 32-bit ALU in the 5-stage MIPS datapath.
- Latches ALUResult/Zero plus EX-stage control, and resolves conditional branches one cycle after EX.
- Formats store data and byte enables for sb/sh/sw, and traps misaligned accesses.
- Auto-squashes the instruction that follows a taken branch; supports stall (hold) and flush (bubble).

Parameters:
- DATA_W, 32, datapath width; only 32 supported.
- REG_AW, 5, register-file address width.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Stall  in  1  hold all registers
- Flush  in  1  load a bubble
- InValid  in  1  EX instruction valid
- ALUResult  in  32  ALU output; effective address for memory ops
- Zero  in  1  ALU branch-condition flag (1 = condition true)
- RtData  in  32  store source data
- WriteRegIn  in  5  destination register
- RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, BranchIn  in  1 each  EX control
- MemSizeIn  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- BranchTargetIn  in  32  computed branch target
- OutValid  out  1  MEM instruction valid
- ALUResultOut  out  32
- StoreData  out  32  lane-replicated store data
- ByteEn  out  4  data-memory byte enables
- WriteRegOut  out  5
- RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut  out  1 each
- MemSizeOut  out  2
- AddrLow  out  2  ALUResultOut[1:0], for load extraction
- BranchTaken  out  1  PC-source select
- BranchTarget  out  32
- Misaligned  out  1  exception flag

Behaviour:
- Reset (async, active-low): all outputs 0, including the internal squash flag. Registers release on the first rising Clk edge after Reset rises.
- Edge priority: Reset > Stall > Flush/squash > load.
  - Stall=1 holds every register; Stall wins over Flush.
  - Flush=1 with Stall=0 loads a bubble.
- Bubble: OutValid=0; RegWriteOut, MemReadOut, MemWriteOut, BranchTaken, Misaligned, ByteEn all 0. Data fields are don't-care; the implementation loads 0.
- Load: all fields are captured from inputs with latency 1.
- BranchTaken is registered as InValid & BranchIn & Zero. BranchTarget is captured in the same edge.
- Squash: if BranchTaken=1 at an unstalled edge, the instruction presented on that edge is loaded as a bubble regardless of InValid. The squash clears BranchTaken in the same edge, so the squash lasts one cycle.
  - Under Stall, BranchTaken holds; the squash applies at the first unstalled edge.
- Byte enables, with a = ALUResult[1:0], for MemRead or MemWrite:
  - byte: ByteEn = 0001 << a.
  - half: 0011 if a[1]=0, else 1100.
  - word: 1111.
  - non-memory op: 0000.
- StoreData:
  - byte: {4{RtData[7:0]}}.
  - half: {2{RtData[15:0]}}.
  - word: RtData.
- Misalignment: half with a[0]=1, or word with a≠00, on a valid memory op.
  - Misaligned=1; MemReadOut, MemWriteOut, RegWriteOut, ByteEn forced to 0; OutValid stays 1.
- Invalid input (InValid=0) is loaded as a bubble.
- All arithmetic is pass-through; no width extension.

Test Plan:
- Reset=0 mid-operation with all outputs nonzero → all outputs 0 immediately, without waiting for Clk; first edge after release loads normally.
- sb: ALUResult=0x1003, RtData=0xAABBCCDD, MemWriteIn=1, MemSize=10 → next cycle ByteEn=1000, StoreData=0xDDDDDDDD, AddrLow=11, Misaligned=0.
- sw at ALUResult=0x1002 → Misaligned=1, MemWriteOut=0, ByteEn=0000, OutValid=1. lh at 0x1002 → ByteEn=1100, MemReadOut=1.
- beq (BranchIn=1, Zero=1, target 0x400) followed by addi (RegWriteIn=1) → cycle 1: BranchTaken=1, BranchTarget=0x400; cycle 2: OutValid=0, RegWriteOut=0, BranchTaken=0. With Zero=0 the addi is not squashed.
- Taken branch then Stall=1 for 3 cycles → BranchTaken holds 1 for all 3; first unstalled edge squashes the incoming instruction.
- Stall=1 and Flush=1 together → registers hold. Flush alone → bubble. Valid add with ALUResult=0x7 → ALUResultOut=0x7, RegWriteOut=1, ByteEn=0000.
